// File: rtl/poly_pos_reader.sv
// poly_pos_reader: reads up to 8 consecutive POSITION_RAM entries starting at
// key_i[6:0] and packs them, zero-extended, into one 128-bit host word.
// Optional build macro POS_READ_RANGE_CHECK_EN: flags and zeroes any captured
// position >= N (per-lane err_o); when undefined err_o is constant 8'h00.
`timescale 1ns/1ps

module poly_pos_reader #(
   parameter int unsigned WEIGHT     = 66,
   parameter int unsigned N          = 17669,
   parameter int unsigned LOGW       = 16,
   parameter int unsigned LOG_WEIGHT = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [127:0]          key_i,
   output logic                  ram_rd_en_o,
   output logic [LOG_WEIGHT-1:0] ram_addr_o,
   input  logic [LOGW-1:0]       ram_q_i,
   output logic [127:0]          data_o,
   output logic [3:0]            count_o,
   output logic [7:0]            err_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int unsigned LANES  = 8;
   localparam int unsigned LANE_W = 16;
   localparam int unsigned IDX_W  = 7;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e                          state_q, state_d;
   logic [IDX_W-1:0]                s_q, s_d;
   logic [3:0]                      n_q, n_d;
   logic [3:0]                      idx_q, idx_d;
   logic [LANES-1:0][LANE_W-1:0]    shadow_q, shadow_d;
   logic [LANES-1:0]                sherr_q, sherr_d;
   logic                            cap_vld_q, cap_vld_d;
   logic [2:0]                      cap_lane_q, cap_lane_d;
   logic [2:0]                      rd_lane_q, rd_lane_d;
   logic                            rd_en_q, rd_en_d;
   logic [LOG_WEIGHT-1:0]           addr_q, addr_d;
   logic [127:0]                    data_q, data_d;
   logic [3:0]                      count_q, count_d;
   logic [7:0]                      err_q, err_d;
   logic                            busy_q, busy_d;
   logic                            done_q, done_d;

   logic [7:0]                      start_idx_c;
   logic [7:0]                      remain_c;
   logic [3:0]                      n_c;
   logic [LANE_W-1:0]               lane_val_c;
   logic                            lane_bad_c;
   logic                            unused_c;

   // Bits of key_i above the start index and the range limit in the unchecked build are don't-care.
   assign unused_c = ^{key_i[127:IDX_W], (32'(N) != 32'd0)};

   // Lane count for a request: 8-bit arithmetic so an index past WEIGHT cannot wrap.
   always_comb begin
      start_idx_c = {1'b0, key_i[IDX_W-1:0]};
      remain_c    = 8'(WEIGHT) - start_idx_c;
      n_c         = 4'd0;
      if (start_idx_c >= 8'(WEIGHT)) begin
         n_c = 4'd0;
      end else if (remain_c >= 8'd8) begin
         n_c = 4'd8;
      end else begin
         n_c = remain_c[3:0];
      end
   end

   // Returned RAM word, zero-extended to a lane, with optional out-of-range detection.
   always_comb begin
      lane_val_c = LANE_W'(ram_q_i);
`ifdef POS_READ_RANGE_CHECK_EN
      lane_bad_c = (32'(ram_q_i) >= 32'(N));
`else
      lane_bad_c = 1'b0;
`endif
   end

   // Next-state, capture and output computation.
   always_comb begin
      state_d    = state_q;
      s_d        = s_q;
      n_d        = n_q;
      idx_d      = idx_q;
      shadow_d   = shadow_q;
      sherr_d    = sherr_q;
      cap_vld_d  = rd_en_q;
      cap_lane_d = rd_lane_q;
      rd_lane_d  = rd_lane_q;
      rd_en_d    = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;
      count_d    = count_q;
      err_d      = err_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      // Data for the read issued last cycle lands in its lane now.
      if (cap_vld_q) begin
         shadow_d[cap_lane_q] = lane_bad_c ? '0 : lane_val_c;
         sherr_d[cap_lane_q]  = lane_bad_c;
      end

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               s_d      = key_i[IDX_W-1:0];
               n_d      = n_c;
               shadow_d = '0;
               sherr_d  = '0;
               if (n_c == 4'd0) begin
                  state_d = S_DONE;
                  data_d  = '0;
                  count_d = 4'd0;
                  err_d   = 8'h00;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d   = S_ISSUE;
                  busy_d    = 1'b1;
                  rd_en_d   = 1'b1;
                  addr_d    = LOG_WEIGHT'(key_i[IDX_W-1:0]);
                  rd_lane_d = 3'd0;
                  idx_d     = 4'd1;
               end
            end
         end
         S_ISSUE: begin
            if (idx_q < n_q) begin
               rd_en_d   = 1'b1;
               addr_d    = LOG_WEIGHT'({1'b0, s_q} + {4'b0000, idx_q});
               rd_lane_d = idx_q[2:0];
               idx_d     = idx_q + 4'd1;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Final lane is merged combinationally so results publish with done_o.
            state_d = S_DONE;
            data_d  = shadow_d;
            err_d   = sherr_d;
            count_d = n_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         s_q        <= '0;
         n_q        <= '0;
         idx_q      <= '0;
         shadow_q   <= '0;
         sherr_q    <= '0;
         cap_vld_q  <= 1'b0;
         cap_lane_q <= '0;
         rd_lane_q  <= '0;
         rd_en_q    <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         count_q    <= '0;
         err_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         n_q        <= n_d;
         idx_q      <= idx_d;
         shadow_q   <= shadow_d;
         sherr_q    <= sherr_d;
         cap_vld_q  <= cap_vld_d;
         cap_lane_q <= cap_lane_d;
         rd_lane_q  <= rd_lane_d;
         rd_en_q    <= rd_en_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         count_q    <= count_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign ram_rd_en_o = rd_en_q;
   assign ram_addr_o  = addr_q;
   assign data_o      = data_q;
   assign count_o     = count_q;
   assign err_o       = err_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_poly_pos_reader.sv
// Randomized scoreboard bench for poly_pos_reader with a behavioural RAM and reference model.
`timescale 1ns/1ps

module tb_poly_pos_reader;

   localparam int WEIGHT = 66;
   localparam int N      = 17669;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start_i = 1'b0;
   logic [127:0] key_i = '0;
   logic         ram_rd_en_o;
   logic [6:0]   ram_addr_o;
   logic [15:0]  ram_q_i = '0;
   logic [127:0] data_o;
   logic [3:0]   count_o;
   logic [7:0]   err_o;
   logic         busy_o;
   logic         done_o;

   logic [15:0]  mem [0:WEIGHT-1];
   int           cyc = 0;
   int           checks = 0;
   int           errors = 0;
   int           reads = 0;
   logic         chk_reset = 1'b0;
   logic         end_chk = 1'b0;

   typedef struct {
      logic [127:0] data;
      logic [3:0]   cnt;
      logic [7:0]   err;
      int           n;
      int           s;
      int           c;
      int           due;
   } exp_t;

   exp_t sb[$];

   poly_pos_reader dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .key_i       (key_i),
      .ram_rd_en_o (ram_rd_en_o),
      .ram_addr_o  (ram_addr_o),
      .ram_q_i     (ram_q_i),
      .data_o      (data_o),
      .count_o     (count_o),
      .err_o       (err_o),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single-port RAM, one-cycle read latency.
   always @(posedge clk) begin
      if (ram_rd_en_o && (int'(ram_addr_o) < WEIGHT)) ram_q_i <= mem[ram_addr_o];
   end

   // Expected result: window of up to 8 entries starting at s, clipped at WEIGHT.
   function automatic exp_t model(input int s, input int c);
      exp_t e;
      logic [15:0] v;
      e.data = '0;
      e.err  = '0;
      e.n    = 0;
      e.s    = s;
      e.c    = c;
      for (int k = 0; k < 8; k++) begin
         if (s + k < WEIGHT) begin
            v = mem[s + k];
            e.n++;
`ifdef POS_READ_RANGE_CHECK_EN
            if (int'(v) >= N) e.err[k] = 1'b1;
            else e.data[16*k +: 16] = v;
`else
            e.data[16*k +: 16] = v;
`endif
         end
      end
      e.cnt = 4'(e.n);
      e.due = c + ((e.n == 0) ? 1 : e.n + 2);
      return e;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
      end
   endtask

   // Monitor: compares DUT activity against the head of the scoreboard.
   always @(negedge clk) begin
      if (rst) begin
         reads = 0;
      end else begin
         if (chk_reset) begin
            check("rst_data",  data_o, 128'(0));
            check("rst_count", 128'(count_o), 128'(0));
            check("rst_err",   128'(err_o), 128'(0));
            check("rst_done",  128'(done_o), 128'(0));
            check("rst_busy",  128'(busy_o), 128'(0));
            check("rst_rden",  128'(ram_rd_en_o), 128'(0));
            check("rst_addr",  128'(ram_addr_o), 128'(0));
         end
         if (ram_rd_en_o) begin
            check("rd_addr_range", 128'(int'(ram_addr_o) < WEIGHT), 128'(1));
            if (sb.size() > 0) check("rd_addr", 128'(ram_addr_o), 128'(sb[0].s + reads));
            else check("rd_idle", 128'(ram_rd_en_o), 128'(0));
            reads++;
         end
         if (done_o) begin
            if (sb.size() == 0) begin
               check("done_unexpected", 128'(done_o), 128'(0));
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("data",    data_o, e.data);
               check("count",   128'(count_o), 128'(e.cnt));
               check("err",     128'(err_o), 128'(e.err));
               check("latency", 128'(cyc), 128'(e.due));
               check("nreads",  128'(reads), 128'(e.n));
               check("busy_at_done", 128'(busy_o), 128'(0));
            end
            reads = 0;
         end else if (sb.size() > 0) begin
            if (cyc > sb[0].due) begin
               check("done_missing", 128'(cyc), 128'(sb[0].due));
               void'(sb.pop_front());
               reads = 0;
            end else begin
               check("busy", 128'(busy_o), 128'((cyc > sb[0].c) ? 1 : 0));
            end
         end
         if (end_chk) check("sb_empty", 128'(sb.size()), 128'(0));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rand_pos();
      if ($urandom_range(0, 7) == 0) return 16'($urandom_range(N, 65535));
      return 16'($urandom_range(0, N - 1));
   endfunction

   // Issue one request; mode 0: quiet, 1: start held on every busy/done cycle, 2: random starts.
   task automatic run_req(input int s, input int mode);
      exp_t e;
      int lat;
      key_i   = {$urandom, $urandom, $urandom, 25'($urandom), 7'(s)};
      start_i = 1'b1;
      e = model(s, cyc);
      sb.push_back(e);
      lat = e.due - cyc;
      for (int j = 1; j <= lat; j++) begin
         step();
         start_i = (mode == 1) || ((mode == 2) && ($urandom_range(0, 1) == 1));
         key_i   = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
      start_i = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      for (int i = 0; i < WEIGHT; i++) mem[i] = rand_pos();

      // Reset state
      repeat (3) step();
      rst = 1'b0;
      chk_reset = 1'b1;
      step();
      chk_reset = 1'b0;
      step();

      // Known window at S=0, then tail, then out-of-range indices
      for (int k = 0; k < 8; k++) mem[k] = 16'(k + 1);
      run_req(0, 0);
      run_req(62, 0);
      run_req(66, 0);
      run_req(127, 0);

      // Start pulses while busy and on the done cycle are ignored
      run_req(0, 1);
      run_req(60, 1);
      run_req(70, 1);

      // Reset during ISSUE aborts without done_o
      key_i   = 128'(0);
      start_i = 1'b1;
      e = model(0, cyc);
      sb.push_back(e);
      step();
      start_i = 1'b0;
      step();
      step();
      rst = 1'b1;
      sb.delete();
      step();
      rst = 1'b0;
      chk_reset = 1'b1;
      step();
      chk_reset = 1'b0;
      repeat (12) step();
      run_req(0, 0);

      // Position equal to N
      mem[3] = 16'(N);
      run_req(0, 0);

      // Randomized traffic with boundary-biased start indices
      for (int t = 0; t < 40; t++) begin
         int s;
         for (int r = 0; r < 4; r++) mem[$urandom_range(0, WEIGHT - 1)] = rand_pos();
         if ($urandom_range(0, 3) == 0) s = $urandom_range(0, 127);
         else s = $urandom_range(WEIGHT - 10, WEIGHT + 1);
         run_req(s, 2);
         repeat ($urandom_range(0, 3)) step();
      end

      repeat (5) step();
      end_chk = 1'b1;
      step();
      end_chk = 1'b0;
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
